imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
//  Instruction-memory responder on the core fetch interface (instr_addr -> instr_data, last_pc).
//  Loads the program from a byte stream after reset, then serves fetches with 1-cycle registered read.
//  While loading it drives last_pc = 32'hFFFFFFFF, which holds the core at its reset PC.
//  After loading, last_pc = N-1, which releases the core.
// PARAMETERS
//  ADDR_W  8  word-address width; DEPTH = 2**ADDR_W instruction words
// PORTS
//  clk         in   1   system clock
//  rst_n       in   1   asynchronous reset, active-low
//  in_valid    in   1   loader byte valid
//  in_byte     in   8   loader byte
//  in_ready    out  1   loader may accept a byte; transfer when in_valid & in_ready
//  instr_addr  in   32  word address from core (its pc_next)
//  instr_data  out  32  instruction word, registered
//  last_pc     out  32  final word index; 32'hFFFFFFFF while not running
//  done        out  1   program loaded, core running
//  err         out  1   header word count exceeded DEPTH
// BEHAVIOUR
//  - Clocking: one clock, clk. rst_n is asynchronous, active-low.
//  - Reset values:
//    - state = HDR0; in_ready = 1; instr_data = 32'h00000013 (NOP).
//    - last_pc = 32'hFFFFFFFF; done = 0; err = 0.
//    - byte/word counters = 0. RAM contents are not cleared.
//  - Stream format:
//    - cnt_lo, cnt_hi give N (16-bit, little-endian).
//    - Then 4*N bytes: N words, each little-endian, stored at word addresses 0..N-1.
//  - FSM: HDR0 -> HDR1 -> DATA -> RUN; ERR is terminal until reset.
//    - HDR0: accepts cnt_lo.
//    - HDR1: accepts cnt_hi.
//      - N == 0: go to RUN; last_pc = N-1 = 32'hFFFFFFFF, so the core stays held.
//      - N > DEPTH: go to ERR, err = 1.
//      - Otherwise: go to DATA.
//    - DATA: shift bytes into a 32-bit assembly register; byte_idx is a 2-bit counter.
//      - On the 4th byte, write the assembled word to RAM[word_idx], then word_idx++.
//      - When word_idx reaches N-1 on that write, go to RUN.
//    - RUN/ERR: in_ready = 0; in_valid is ignored.
//  - in_ready = 1 exactly in HDR0, HDR1 and DATA.
//    - in_valid gaps are allowed.
//    - in_byte is sampled only on a transfer.
//  - done = 1 and last_pc = N-1 are registered: both take effect the cycle after the last accepted byte.
//  - Fetch read, registered (1-cycle latency; the core presents pc_next):
//    - Not RUN -> instr_data <= NOP.
//    - instr_addr[31:ADDR_W] != 0 (this includes 32'hFFFFFFFF) -> instr_data <= NOP.
//    - Otherwise -> instr_data <= RAM[instr_addr[ADDR_W-1:0]].
//  - Write/read collision: cannot occur, because reads return NOP in every non-RUN state.
//  - Reset mid-load: immediately returns to HDR0; the partial word is discarded; last_pc goes back to all-ones.
//    A fresh stream reloads from address 0.
//  - Width rules:
//    - N is compared against DEPTH as a 17-bit value.
//    - last_pc = {16'b0, N} - 1 in 32 bits.
// STRUCTURE
//  - Shared header imem_defs.vh holds:
//    - NOP_INSTR = 32'h00000013;
//    - state encodings HDR0/HDR1/DATA/RUN/ERR;
//    - PC_HOLD = 32'hFFFFFFFF.
//  - Sub-module imem_ram: DEPTH x 32, one synchronous write port, one synchronous read port. Inferable as block RAM.
//  - The top level holds the FSM, counters, byte assembly and the NOP/range muxing.
// TESTING
//  1. Load N = 2, bytes 02 00 93 00 50 00 13 81 10 00:
//     - done = 1 and last_pc = 1 the cycle after the last byte;
//     - instr_addr = 0 -> next cycle instr_data = 32'h00500093;
//     - instr_addr = 1 -> 32'h00108113.
//  2. During the load in test 1, instr_addr = 0: instr_data = 32'h00000013, last_pc = 32'hFFFFFFFF, done = 0.
//  3. Header 00 00 (N = 0): done = 1, last_pc = 32'hFFFFFFFF, in_ready = 0.
//  4. Header 01 01 (N = 257, ADDR_W = 8): err = 1, in_ready = 0, done = 0, last_pc = 32'hFFFFFFFF.
//     Further bytes are ignored.
//  5. Program loaded, then:
//     - instr_addr = 32'h100 -> NOP;
//     - instr_addr = 32'hFFFFFFFF -> NOP;
//     - in_valid pulses while in RUN leave RAM unchanged.
//  6. rst_n asserted low after 5 data bytes: state returns to HDR0, in_ready = 1, last_pc = 32'hFFFFFFFF.
//     Reload the test 1 stream -> same results as test 1.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared constants, state type and helpers for the instruction-memory loader.
package imem_loader_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] PC_HOLD   = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    HDR0 = 3'd0,
    HDR1 = 3'd1,
    DATA = 3'd2,
    RUN  = 3'd3,
    ERR  = 3'd4
  } load_state_e;

  // Index of the final word of an N-word program; N == 0 wraps to all-ones.
  function automatic logic [31:0] last_index(input logic [15:0] n);
    return {16'b0, n} - 32'd1;
  endfunction

endpackage

// File: rtl/imem_loader_ram.sv
// Simple dual-port instruction RAM: one synchronous write port, one registered read port.
module imem_ram #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [31:0]       wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [31:0]       rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [31:0] mem [DEPTH];

  // No reset on the array or the read register so the tools can map this onto block RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/imem_loader.sv
// Instruction memory that loads its program from a byte stream, then serves core fetches.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [7:0]  in_byte,
  output logic        in_ready,
  input  logic [31:0] instr_addr,
  output logic [31:0] instr_data,
  output logic [31:0] last_pc,
  output logic        done,
  output logic        err
);

  localparam int          DEPTH   = 2 ** ADDR_W;
  localparam logic [16:0] DEPTH17 = 17'(DEPTH);

  load_state_e       state_q, state_d;
  logic [7:0]        cnt_lo_q;
  logic [15:0]       n_q;
  logic [1:0]        byte_idx_q;
  logic [ADDR_W-1:0] word_idx_q;
  logic [23:0]       asm_q;
  logic              done_q, err_q;
  logic [31:0]       last_pc_q;
  logic              fetch_sel_q;

  logic              xfer;
  logic [15:0]       hdr_n;
  logic              hdr_too_big;
  logic              last_word;
  logic              word_done;
  logic              ram_we;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;

  assign xfer        = in_valid & in_ready;
  assign hdr_n       = {in_byte, cnt_lo_q};
  assign hdr_too_big = {1'b0, hdr_n} > DEPTH17;
  assign last_word   = 16'(word_idx_q) == (n_q - 16'd1);
  assign word_done   = (state_q == DATA) && xfer && (byte_idx_q == 2'd3);
  assign ram_wdata   = {in_byte, asm_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HDR0;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      HDR0: if (xfer) state_d = HDR1;
      HDR1: begin
        if (xfer) begin
          if (hdr_n == 16'd0) begin
            state_d = RUN;
          end else if (hdr_too_big) begin
            state_d = ERR;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: if (word_done && last_word) state_d = RUN;
      RUN:  state_d = RUN;
      ERR:  state_d = ERR;
      default: state_d = HDR0;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    ram_we   = 1'b0;
    case (state_q)
      HDR0, HDR1: in_ready = 1'b1;
      DATA: begin
        in_ready = 1'b1;
        ram_we   = word_done;
      end
      default: begin
        in_ready = 1'b0;
        ram_we   = 1'b0;
      end
    endcase
  end

  // Bytes arrive little-endian, so each new byte enters at the top and slides down.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_lo_q   <= 8'd0;
      n_q        <= 16'd0;
      byte_idx_q <= 2'd0;
      word_idx_q <= '0;
      asm_q      <= 24'd0;
    end else if (xfer) begin
      case (state_q)
        HDR0: cnt_lo_q <= in_byte;
        HDR1: begin
          n_q        <= hdr_n;
          byte_idx_q <= 2'd0;
          word_idx_q <= '0;
        end
        DATA: begin
          byte_idx_q <= byte_idx_q + 2'd1;
          asm_q      <= {in_byte, asm_q[23:8]};
          if (byte_idx_q == 2'd3) begin
            word_idx_q <= word_idx_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      last_pc_q   <= PC_HOLD;
      fetch_sel_q <= 1'b0;
    end else begin
      if ((state_d == RUN) && (state_q != RUN)) begin
        done_q    <= 1'b1;
        last_pc_q <= last_index((state_q == HDR1) ? hdr_n : n_q);
      end
      if (state_d == ERR) begin
        err_q <= 1'b1;
      end
      fetch_sel_q <= (state_q == RUN) && (instr_addr[31:ADDR_W] == '0);
    end
  end

  imem_ram #(
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .waddr(word_idx_q),
    .wdata(ram_wdata),
    .raddr(instr_addr[ADDR_W-1:0]),
    .rdata(ram_rdata)
  );

  // The read register inside the RAM has no reset, so the NOP select is the registered part.
  assign instr_data = fetch_sel_q ? ram_rdata : NOP_INSTR;
  assign last_pc    = last_pc_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed stream tests, a fetch vector table and randomized loads.
`timescale 1ns/1ps
module tb_imem_loader;

  localparam int          ADDR_W = 8;
  localparam int          DEPTH  = 256;
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] HOLD   = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_byte = 8'd0;
  logic        in_ready;
  logic [31:0] instr_addr = 32'd0;
  logic [31:0] instr_data;
  logic [31:0] last_pc;
  logic        done;
  logic        err;

  int checks = 0;
  int errors = 0;

  logic [31:0] model_mem [DEPTH];
  bit          model_written [DEPTH];

  typedef struct {
    logic [31:0] addr;
    logic [31:0] exp;
  } fetch_vec_t;

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_byte   (in_byte),
    .in_ready  (in_ready),
    .instr_addr(instr_addr),
    .instr_data(instr_data),
    .last_pc   (last_pc),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One byte offered for exactly one clock; in_byte carries junk otherwise.
  task automatic applyStimulus(input logic [7:0] b);
    @(negedge clk);
    in_valid = 1'b1;
    in_byte  = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_byte  = 8'($urandom);
  endtask

  task automatic doReset(input string tag);
    @(negedge clk);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #2;
    checkOutput({tag, "_rst_in_ready"}, {31'b0, in_ready}, 32'd1);
    checkOutput({tag, "_rst_last_pc"}, last_pc, HOLD);
    checkOutput({tag, "_rst_done"}, {31'b0, done}, 32'd0);
    checkOutput({tag, "_rst_err"}, {31'b0, err}, 32'd0);
    checkOutput({tag, "_rst_instr"}, instr_data, NOP);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic fetch(input logic [31:0] addr, output logic [31:0] data);
    @(negedge clk);
    instr_addr = addr;
    @(posedge clk);
    #1;
    data = instr_data;
  endtask

  function automatic logic [31:0] modelFetch(input logic [31:0] addr);
    if (addr[31:8] != 24'd0) return NOP;
    return model_mem[addr[7:0]];
  endfunction

  // Sends header plus every word; the model only commits the words if N fits.
  task automatic loadProgram(input string tag, input logic [15:0] n, input logic [31:0] words[$],
                             input bit gaps, input bit watch);
    logic [7:0]  bytes[$];
    logic [31:0] exp_last;
    bytes.push_back(n[7:0]);
    bytes.push_back(n[15:8]);
    foreach (words[w]) begin
      for (int k = 0; k < 4; k++) bytes.push_back(8'(words[w] >> (8 * k)));
    end
    if (watch) begin
      @(negedge clk);
      instr_addr = 32'd0;
    end
    for (int i = 0; i < bytes.size(); i++) begin
      if (gaps && ($urandom % 3 == 0)) idle(1 + ($urandom % 3));
      applyStimulus(bytes[i]);
      if (watch && i < bytes.size() - 1) begin
        checkOutput({tag, "_load_instr"}, instr_data, NOP);
        checkOutput({tag, "_load_last_pc"}, last_pc, HOLD);
        checkOutput({tag, "_load_done"}, {31'b0, done}, 32'd0);
      end
    end
    if (int'(n) <= DEPTH) begin
      for (int w = 0; w < int'(n); w++) begin
        model_mem[w]     = words[w];
        model_written[w] = 1'b1;
      end
    end
    exp_last = (int'(n) > DEPTH) ? HOLD : 32'(int'(n) - 1);
    checkOutput({tag, "_done"}, {31'b0, done}, (int'(n) > DEPTH) ? 32'd0 : 32'd1);
    checkOutput({tag, "_err"}, {31'b0, err}, (int'(n) > DEPTH) ? 32'd1 : 32'd0);
    checkOutput({tag, "_last_pc"}, last_pc, exp_last);
    checkOutput({tag, "_in_ready"}, {31'b0, in_ready}, 32'd0);
  endtask

  initial begin
    logic [31:0] prog1[$];
    logic [31:0] rwords[$];
    logic [31:0] got;
    logic [31:0] addr;
    fetch_vec_t  vecs[7];
    int          n;

    prog1 = '{32'h0050_0093, 32'h0010_8113};
    vecs[0] = '{32'h0000_0000, 32'h0050_0093};
    vecs[1] = '{32'h0000_0001, 32'h0010_8113};
    vecs[2] = '{32'h0000_0100, NOP};
    vecs[3] = '{32'hFFFF_FFFF, NOP};
    vecs[4] = '{32'h0001_0000, NOP};
    vecs[5] = '{32'h8000_0001, NOP};
    vecs[6] = '{32'h0000_0000, 32'h0050_0093};
    for (int i = 0; i < DEPTH; i++) model_written[i] = 1'b0;

    // Tests 1 and 2: the reference stream, watched while loading.
    doReset("t1");
    loadProgram("t1", 16'd2, prog1, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) begin
      fetch(vecs[i].addr, got);
      checkOutput($sformatf("t1_vec%0d", i), got, vecs[i].exp);
    end

    // Test 5: bytes offered in RUN must not touch the RAM.
    for (int i = 0; i < 8; i++) applyStimulus(8'hA5 + 8'(i));
    checkOutput("t5_in_ready", {31'b0, in_ready}, 32'd0);
    checkOutput("t5_last_pc", last_pc, 32'd1);
    fetch(32'd0, got);
    checkOutput("t5_word0", got, 32'h0050_0093);
    fetch(32'd1, got);
    checkOutput("t5_word1", got, 32'h0010_8113);

    // Test 3: empty program keeps the core held, RAM keeps old contents.
    doReset("t3");
    rwords.delete();
    loadProgram("t3", 16'd0, rwords, 1'b0, 1'b0);
    checkOutput("t3_last_pc_hold", last_pc, HOLD);
    fetch(32'd1, got);
    checkOutput("t3_old_word1", got, 32'h0010_8113);

    // Test 4: oversize header goes to ERR and ignores the rest.
    doReset("t4");
    rwords = '{32'hDEAD_BEEF, 32'hCAFE_F00D};
    loadProgram("t4", 16'd257, rwords, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(8'($urandom));
    checkOutput("t4_err_sticky", {31'b0, err}, 32'd1);
    checkOutput("t4_done_low", {31'b0, done}, 32'd0);
    fetch(32'd0, got);
    checkOutput("t4_fetch_nop", got, NOP);

    // Test 6: reset after 5 bytes of the stream, then a clean reload.
    doReset("t6a");
    applyStimulus(8'h02);
    applyStimulus(8'h00);
    applyStimulus(8'h93);
    applyStimulus(8'h00);
    applyStimulus(8'h50);
    doReset("t6b");
    loadProgram("t6", 16'd2, prog1, 1'b1, 1'b1);
    fetch(32'd0, got);
    checkOutput("t6_word0", got, 32'h0050_0093);
    fetch(32'd1, got);
    checkOutput("t6_word1", got, 32'h0010_8113);

    // Randomized loads with valid gaps, checked against the byte-stream model.
    for (int it = 0; it < 4; it++) begin
      n = 1 + int'($urandom % 24);
      rwords.delete();
      for (int w = 0; w < n; w++) rwords.push_back($urandom);
      doReset($sformatf("r%0d", it));
      loadProgram($sformatf("r%0d", it), 16'(n), rwords, 1'b1, 1'b0);
      for (int f = 0; f < 12; f++) begin
        if ($urandom % 4 == 0) begin
          addr = $urandom;
          if (addr[31:8] == 24'd0) addr = addr | 32'h0000_0100;
        end else begin
          addr = 32'($urandom % n);
        end
        fetch(addr, got);
        checkOutput($sformatf("r%0d_fetch_%h", it, addr), got, modelFetch(addr));
      end
    end

    // Full-depth program is accepted, not an error.
    rwords.delete();
    for (int w = 0; w < DEPTH; w++) rwords.push_back($urandom);
    doReset("full");
    loadProgram("full", 16'd256, rwords, 1'b0, 1'b0);
    fetch(32'd255, got);
    checkOutput("full_word255", got, modelFetch(32'd255));
    fetch(32'd0, got);
    checkOutput("full_word0", got, modelFetch(32'd0));
    fetch(32'd128, got);
    checkOutput("full_word128", got, modelFetch(32'd128));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
